register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 85 ++++++++
 tb/tb_register_file.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// RV32I-style integer register file: 2**ADDR_WIDTH x DATA_WIDTH, x0 hardwired to zero,
// three combinational read ports (rs1, rs2, dbg). Optional write-through forwarding: RF_WRITE_BYPASS_EN.

module rf_read_port #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] regs,
   input  logic [ADDR_WIDTH-1:0]                    addr,
   output logic [DATA_WIDTH-1:0]                    data
);
   // x0 is forced to zero here as well as in storage so the port never depends on it
   always_comb data = (addr == '0) ? '0 : regs[addr];
endmodule

module register_file #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 5,
   parameter logic [DATA_WIDTH-1:0] SP_RESET   = DATA_WIDTH'(32'h7FFF_EFFC),
   parameter logic [DATA_WIDTH-1:0] GP_RESET   = DATA_WIDTH'(32'h1000_8000)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic [ADDR_WIDTH-1:0] rs1_addr,
   input  logic [ADDR_WIDTH-1:0] rs2_addr,
   output logic [DATA_WIDTH-1:0] rs1_data,
   output logic [DATA_WIDTH-1:0] rs2_data,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   output logic [DATA_WIDTH-1:0] dbg_data,
   output logic [31:0]           wr_count
);
   localparam int NREG  = 2**ADDR_WIDTH;
   localparam int NPORT = 3;

   logic [NREG-1:0][DATA_WIDTH-1:0]  regs;
   logic [NPORT-1:0][ADDR_WIDTH-1:0] port_addr;
   logic [NPORT-1:0][DATA_WIDTH-1:0] lookup;
   logic [NPORT-1:0][DATA_WIDTH-1:0] port_data;
   logic                             wr_en;

   function automatic logic [DATA_WIDTH-1:0] reset_value(input int idx);
      if (idx == 2)      return SP_RESET;
      else if (idx == 3) return GP_RESET;
      else               return '0;
   endfunction

   assign wr_en     = we && (rd_addr != '0);
   assign port_addr = {dbg_addr, rs2_addr, rs1_addr};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= reset_value(i);
         wr_count <= '0;
      end else if (wr_en) begin
         regs[rd_addr] <= rd_data;
         wr_count      <= wr_count + 32'd1;
      end
   end

   generate
      for (genvar p = 0; p < NPORT; p++) begin : g_port
         rf_read_port #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
         ) u_port (
            .regs(regs),
            .addr(port_addr[p]),
            .data(lookup[p])
         );
`ifdef RF_WRITE_BYPASS_EN
         // forward the in-flight write so a reader in the same cycle sees the new value
         assign port_data[p] = (wr_en && (port_addr[p] == rd_addr)) ? rd_data : lookup[p];
`else
         assign port_data[p] = lookup[p];
`endif
      end
   endgenerate

   assign rs1_data = port_data[0];
   assign rs2_data = port_data[1];
   assign dbg_data = port_data[2];
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: expected values are queued when stimulus is driven
// and popped/compared against DUT outputs at the following negedge.

module tb_register_file;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam logic [31:0] SP = 32'h7FFF_EFFC;
   localparam logic [31:0] GP = 32'h1000_8000;
`ifdef RF_WRITE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          we;
   logic [AW-1:0] rd_addr, rs1_addr, rs2_addr, dbg_addr;
   logic [DW-1:0] rd_data, rs1_data, rs2_data, dbg_data;
   logic [31:0]   wr_count;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   register_file #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SP_RESET(SP), .GP_RESET(GP)
   ) dut (
      .clk(clk), .rst(rst), .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_count(wr_count)
   );

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      q.push_back(e);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (q.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_underflow observed=%h expected=<entry>", obs);
      end else begin
         e = q.pop_front();
         assert (obs === e.val) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; rd_addr = '0; rd_data = '0;
      rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;

      // writes attempted while reset is held must be blocked
      we = 1'b1; rd_addr = 5'd4; rd_data = 32'hAAAA_5555;
      rs1_addr = 5'd2;
      push("in_reset_sp", SP);
      @(negedge clk); pop_check(rs1_data);
      step(); step();
      we = 1'b0;
      rst = 1'b0;

      // reset values
      rs1_addr = 5'd2; rs2_addr = 5'd3; dbg_addr = 5'd5;
      push("reset_x2", SP); push("reset_x3", GP); push("reset_x5", 32'h0); push("reset_count", 32'h0);
      @(negedge clk);
      pop_check(rs1_data); pop_check(rs2_data); pop_check(dbg_data); pop_check(wr_count);
      dbg_addr = 5'd4;
      push("reset_blocked_x4", 32'h0);
      @(negedge clk); pop_check(dbg_data);

      // basic write, first edge after reset release
      step();
      we = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEAD_BEEF;
      step();
      we = 1'b0; rs1_addr = 5'd5;
      push("write_x5", 32'hDEAD_BEEF); push("write_count", 32'd1);
      @(negedge clk); pop_check(rs1_data); pop_check(wr_count);

      // write to x0: no forwarding, no store, no count
      step();
      we = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFF_FFFF; rs1_addr = 5'd0; rs2_addr = 5'd0;
      push("x0_during_rs1", 32'h0);
      @(negedge clk); pop_check(rs1_data);
      step();
      we = 1'b0;
      push("x0_after_rs1", 32'h0); push("x0_after_rs2", 32'h0); push("x0_count", 32'd1);
      @(negedge clk); pop_check(rs1_data); pop_check(rs2_data); pop_check(wr_count);

      // same-cycle read/write of x7
      step();
      we = 1'b1; rd_addr = 5'd7; rd_data = 32'd1;
      step();
      rd_data = 32'd9; rs1_addr = 5'd7; rs2_addr = 5'd7; dbg_addr = 5'd7;
      push("rw_same_rs1", BYP ? 32'd9 : 32'd1);
      push("rw_same_rs2", BYP ? 32'd9 : 32'd1);
      push("rw_same_dbg", BYP ? 32'd9 : 32'd1);
      @(negedge clk); pop_check(rs1_data); pop_check(rs2_data); pop_check(dbg_data);
      step();
      we = 1'b0;
      push("rw_next_rs1", 32'd9); push("rw_count", 32'd3);
      @(negedge clk); pop_check(rs1_data); pop_check(wr_count);

      // hold with we=0
      rd_addr = 5'd5; rd_data = 32'h0BAD_0BAD;
      repeat (4) step();
      rs2_addr = 5'd5;
      push("hold_x5", 32'hDEAD_BEEF); push("hold_count", 32'd3);
      @(negedge clk); pop_check(rs2_data); pop_check(wr_count);

      // reset asserted asynchronously mid-write, held over the edge, released between edges
      step();
      we = 1'b1; rd_addr = 5'd10; rd_data = 32'h1234;
      #2 rst = 1'b1;
      #1;
      push("async_rst_count", 32'h0);
      pop_check(wr_count);
      step();
      we = 1'b0;
      #2 rst = 1'b0;
      rs1_addr = 5'd10; rs2_addr = 5'd2; dbg_addr = 5'd5;
      push("rst_mid_x10", 32'h0); push("rst_mid_x2", SP); push("rst_mid_x5", 32'h0); push("rst_mid_count", 32'h0);
      @(negedge clk);
      pop_check(rs1_data); pop_check(rs2_data); pop_check(dbg_data); pop_check(wr_count);

      // sweep x1..x31 with index*3, read back on all three ports
      step();
      for (int i = 1; i < 32; i++) begin
         we = 1'b1; rd_addr = AW'(i); rd_data = 32'(i * 3);
         step();
      end
      we = 1'b0;
      push("sweep_count", 32'd31);
      @(negedge clk); pop_check(wr_count);
      for (int i = 0; i < 32; i++) begin
         rs1_addr = AW'(i); rs2_addr = AW'(31 - i); dbg_addr = AW'(i);
         push($sformatf("sweep_rs1_x%0d", i), 32'(i * 3));
         push($sformatf("sweep_rs2_x%0d", 31 - i), 32'((31 - i) * 3));
         push($sformatf("sweep_dbg_x%0d", i), 32'(i * 3));
         #2;
         pop_check(rs1_data); pop_check(rs2_data); pop_check(dbg_data);
      end

      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover observed=%0d expected=0", q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
